// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared types and widths for the PC/fetch sequencer.
package pc_sequencer_pkg;
  localparam int PC_W_DEFAULT = 10;
  localparam int OFF_W = 9;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {sIDLE, sRUN, sHALTED} pc_state_t;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/pc_branch_adder.sv
// pc_branch_adder: wrapped PC +/- unsigned offset; offset is zero-extended or truncated to PC_W.
module pc_branch_adder
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [OFF_W-1:0] offset,
  input  logic             sign,
  output logic [PC_W-1:0]  next_pc
);
  logic [PC_W-1:0] off;
  assign off = PC_W'(offset);
  assign next_pc = sign ? pc - off : pc + off;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and IDLE/RUN/HALTED fetch sequencer with Start/Done handshake.
// Define INSTR_COUNT_EN to add a saturating 16-bit executed-instruction counter output.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             stall,
  input  logic             is_branch,
  input  logic [OFF_W-1:0] bOFFSET,
  input  logic             bSIGN,
  input  logic             alu_reset,
  input  logic             alu_halt,
  output logic [PC_W-1:0]  PC,
  output logic             fetch_en,
`ifdef INSTR_COUNT_EN
  output logic [CNT_W-1:0] instr_count,
`endif
  output logic             Done
);
  pc_state_t state, state_n;
  logic [PC_W-1:0] pc_n, pc_step;
  logic [OFF_W-1:0] step_off;
  logic start_q, accept, run_go;
  assign accept = Start & ~start_q & (state != sRUN);
  assign run_go = (state == sRUN) & ~stall;
  assign fetch_en = run_go;
  assign Done = state == sHALTED;
  // One adder serves both the branch and the sequential +1 path.
  assign step_off = is_branch ? bOFFSET : OFF_W'(1);
  pc_branch_adder #(.PC_W(PC_W)) u_adder (
    .pc(PC),
    .offset(step_off),
    .sign(is_branch & bSIGN),
    .next_pc(pc_step)
  );
  always_comb begin
    state_n = accept ? sRUN : (run_go & alu_reset & alu_halt) ? sHALTED : state;
    pc_n = accept ? START_ADDR : ~run_go ? PC : alu_reset ? (alu_halt ? PC : START_ADDR) : pc_step;
  end
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= sIDLE;
      PC <= START_ADDR;
      start_q <= 1'b0;
    end else begin
      state <= state_n;
      PC <= pc_n;
      start_q <= Start;
    end
  end
`ifdef INSTR_COUNT_EN
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) instr_count <= '0;
    else if (accept) instr_count <= '0;
    else if (fetch_en) instr_count <= sat_inc(instr_count);
  end
`endif
endmodule
